// File: rtl/multi_core_cmd_loader.sv
// multi_core_cmd_loader
//   Host-side loader for per-core command memories. Narrow host chunks are
//   assembled into a full CMD_WIDTH command in a staging register. The
//   command is then committed atomically to the selected core's memory.
//   Each core reads its memory through a READ_LATENCY-deep pipeline.
//
// Optional feature: define CMD_MEM_READBACK_EN to add a host readback port.
//   The readback port returns one HOST_WIDTH chunk per request.
//
// Ports
//   clk           clock
//   reset         asynchronous active-low reset
//   host_wvalid   chunk write request
//   host_wready   loader accepts a chunk this cycle (low only while committing)
//   host_waddr    {core, cmd_addr, chunk}; chunk 0 holds the LS bits of a command
//   host_wdata    chunk data
//   commit_pulse  one-cycle pulse after a command has been written to memory
//   err_seq       one-cycle pulse: out-of-order chunk or core/addr change mid-fill
//   err_addr      one-cycle pulse: accepted chunk addressed a core >= N_CORES
//   commit_count  commits since reset, wraps at 2**32
//   instr_ptr     packed per-core read addresses, core 0 in the LS slice
//   cmd_out       packed per-core commands, core 0 in the LS slice
//   host_raddr, host_rvalid, host_rdata, host_rdvalid   (CMD_MEM_READBACK_EN only)
//
// When MEM_TO_CMD == 1 the chunk field is kept 1 bit wide. Chunk 0 is the only legal value.
module multi_core_cmd_loader #(
  parameter int N_CORES        = 2,
  parameter int CMD_WIDTH      = 128,
  parameter int HOST_WIDTH     = 32,
  parameter int CMD_ADDR_WIDTH = 10,
  parameter int READ_LATENCY   = 3,
  parameter int CORE_SEL_WIDTH = 1,
  localparam int MEM_TO_CMD    = CMD_WIDTH / HOST_WIDTH,
  localparam int CHUNK_W       = (MEM_TO_CMD > 1) ? $clog2(MEM_TO_CMD) : 1,
  localparam int HADDR_W       = CORE_SEL_WIDTH + CMD_ADDR_WIDTH + CHUNK_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                host_wvalid,
  output logic                                host_wready,
  input  logic [HADDR_W-1:0]                  host_waddr,
  input  logic [HOST_WIDTH-1:0]               host_wdata,
  output logic                                commit_pulse,
  output logic                                err_seq,
  output logic                                err_addr,
  output logic [31:0]                         commit_count,
`ifdef CMD_MEM_READBACK_EN
  input  logic [HADDR_W-1:0]                  host_raddr,
  input  logic                                host_rvalid,
  output logic [HOST_WIDTH-1:0]               host_rdata,
  output logic                                host_rdvalid,
`endif
  input  logic [N_CORES*CMD_ADDR_WIDTH-1:0]   instr_ptr,
  output logic [N_CORES*CMD_WIDTH-1:0]        cmd_out
);

  localparam int DEPTH      = 2 ** CMD_ADDR_WIDTH;
  localparam int CORE_IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [CHUNK_W-1:0]        LAST_CHUNK = CHUNK_W'(MEM_TO_CMD - 1);
  localparam logic [CORE_SEL_WIDTH:0]   N_CORES_C  = (CORE_SEL_WIDTH + 1)'(N_CORES);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMMIT} state_t;

  state_t                      state_q, state_d;
  logic [CHUNK_W-1:0]          expect_q, expect_d;
  logic [CORE_SEL_WIDTH-1:0]   core_q, core_d;
  logic [CMD_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                        commit_pulse_q, err_seq_q, err_addr_q;
  logic                        err_seq_d, err_addr_d, stage_we;
  logic [31:0]                 commit_count_q;
  logic [CMD_WIDTH-1:0]        staging_q;
  logic [CMD_WIDTH-1:0]        mem_q [N_CORES][DEPTH];

  logic [CHUNK_W-1:0]          w_chunk;
  logic [CMD_ADDR_WIDTH-1:0]   w_addr;
  logic [CORE_SEL_WIDTH-1:0]   w_core;
  logic                        w_core_ok, accept, same_cmd, mem_we;

  assign w_chunk   = host_waddr[CHUNK_W-1:0];
  assign w_addr    = host_waddr[CHUNK_W +: CMD_ADDR_WIDTH];
  assign w_core    = host_waddr[CHUNK_W + CMD_ADDR_WIDTH +: CORE_SEL_WIDTH];
  assign w_core_ok = ({1'b0, w_core} < N_CORES_C);
  assign accept    = host_wvalid & host_wready;
  assign same_cmd  = (w_core == core_q) && (w_addr == addr_q) && (w_chunk == expect_q);

  assign host_wready  = (state_q != S_COMMIT);
  assign commit_pulse = commit_pulse_q;
  assign err_seq      = err_seq_q;
  assign err_addr     = err_addr_q;
  assign commit_count = commit_count_q;

  always_comb begin
    state_d    = state_q;
    expect_d   = expect_q;
    core_d     = core_q;
    addr_d     = addr_q;
    stage_we   = 1'b0;
    err_seq_d  = 1'b0;
    err_addr_d = 1'b0;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (accept) begin
          if (!w_core_ok) begin
            // Bad core wins over a sequence error and drops any partial fill.
            err_addr_d = 1'b1;
            state_d    = S_IDLE;
            expect_d   = '0;
          end else if (state_q == S_FILL && same_cmd) begin
            stage_we = 1'b1;
            if (expect_q == LAST_CHUNK) begin
              state_d  = S_COMMIT;
              expect_d = '0;
            end else begin
              expect_d = expect_q + 1'b1;
            end
          end else begin
            // A mismatch in FILL is an error. An unstarted fill in IDLE is only an error for a non-zero chunk.
            // In both states, chunk 0 always (re)starts a fill.
            err_seq_d = (state_q == S_FILL) || (w_chunk != '0);
            state_d   = S_IDLE;
            expect_d  = '0;
            if (w_chunk == '0) begin
              core_d   = w_core;
              addr_d   = w_addr;
              stage_we = 1'b1;
              expect_d = CHUNK_W'(1);
              state_d  = (MEM_TO_CMD == 1) ? S_COMMIT : S_FILL;
            end
          end
        end
      end
      S_COMMIT: begin
        state_d  = S_IDLE;
        expect_d = '0;
      end
      default: begin
        state_d  = S_IDLE;
        expect_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      expect_q       <= '0;
      core_q         <= '0;
      addr_q         <= '0;
      commit_pulse_q <= 1'b0;
      err_seq_q      <= 1'b0;
      err_addr_q     <= 1'b0;
      commit_count_q <= '0;
    end else begin
      state_q        <= state_d;
      expect_q       <= expect_d;
      core_q         <= core_d;
      addr_q         <= addr_d;
      commit_pulse_q <= (state_q == S_COMMIT);
      err_seq_q      <= err_seq_d;
      err_addr_q     <= err_addr_d;
      if (state_q == S_COMMIT) commit_count_q <= commit_count_q + 32'd1;
    end
  end

  // Staging holds data only. A restarted fill overwrites every chunk before the next commit.
  always_ff @(posedge clk) begin
    if (stage_we) staging_q[w_chunk*HOST_WIDTH +: HOST_WIDTH] <= host_wdata;
  end

  // Gate the write with reset so that a commit edge coincident with reset assertion writes nothing.
  assign mem_we = (state_q == S_COMMIT) && reset;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[core_q[CORE_IDX_W-1:0]][addr_q] <= staging_q;
  end

  // Read stage 0 samples the memory array. It sees pre-commit contents on a
  // same-edge collision (read-first). Later stages only delay the data.
  for (genvar c = 0; c < N_CORES; c++) begin : g_rd
    logic [CMD_WIDTH-1:0] pipe_q [READ_LATENCY];
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int s = 0; s < READ_LATENCY; s++) pipe_q[s] <= '0;
      end else begin
        pipe_q[0] <= mem_q[c][instr_ptr[c*CMD_ADDR_WIDTH +: CMD_ADDR_WIDTH]];
        for (int s = 1; s < READ_LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
      end
    end
    assign cmd_out[c*CMD_WIDTH +: CMD_WIDTH] = pipe_q[READ_LATENCY-1];
  end

`ifdef CMD_MEM_READBACK_EN
  logic [CHUNK_W-1:0]        r_chunk;
  logic [CMD_ADDR_WIDTH-1:0] r_addr;
  logic [CORE_SEL_WIDTH-1:0] r_core;
  logic                      r_core_ok;
  logic [CMD_WIDTH-1:0]      r_word;
  logic [HOST_WIDTH-1:0]     rb_data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0]   rb_vld_q;

  assign r_chunk   = host_raddr[CHUNK_W-1:0];
  assign r_addr    = host_raddr[CHUNK_W +: CMD_ADDR_WIDTH];
  assign r_core    = host_raddr[CHUNK_W + CMD_ADDR_WIDTH +: CORE_SEL_WIDTH];
  assign r_core_ok = ({1'b0, r_core} < N_CORES_C);
  assign r_word    = mem_q[r_core[CORE_IDX_W-1:0]][r_addr];

  // The readback path is an independent read pipeline. It never blocks the core reads or host writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < READ_LATENCY; s++) rb_data_q[s] <= '0;
      rb_vld_q <= '0;
    end else begin
      rb_vld_q[0]  <= host_rvalid;
      rb_data_q[0] <= (host_rvalid && r_core_ok) ? r_word[r_chunk*HOST_WIDTH +: HOST_WIDTH] : '0;
      for (int s = 1; s < READ_LATENCY; s++) begin
        rb_vld_q[s]  <= rb_vld_q[s-1];
        rb_data_q[s] <= rb_data_q[s-1];
      end
    end
  end

  assign host_rdata   = rb_data_q[READ_LATENCY-1];
  assign host_rdvalid = rb_vld_q[READ_LATENCY-1];
`endif

endmodule

// File: tb/tb_multi_core_cmd_loader.sv
// Testbench for multi_core_cmd_loader. Uses a 2-bit core field so that
// out-of-range cores (2, 3) can be exercised against N_CORES=2.
module tb_multi_core_cmd_loader;
  localparam int NC = 2, CW = 128, HW = 32, AW = 10, RL = 3, CSW = 2;
  localparam int HAW = CSW + AW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic           host_wvalid = 1'b0;
  logic           host_wready;
  logic [HAW-1:0] host_waddr = '0;
  logic [HW-1:0]  host_wdata = '0;
  logic           commit_pulse, err_seq, err_addr;
  logic [31:0]    commit_count;
  logic [AW-1:0]  ptr0 = '0, ptr1 = '0;
  logic [NC*AW-1:0] instr_ptr;
  logic [NC*CW-1:0] cmd_out;
  assign instr_ptr = {ptr1, ptr0};
`ifdef CMD_MEM_READBACK_EN
  logic [HAW-1:0] host_raddr = '0;
  logic           host_rvalid = 1'b0;
  logic [HW-1:0]  host_rdata;
  logic           host_rdvalid;
`endif

  multi_core_cmd_loader #(
    .N_CORES(NC), .CMD_WIDTH(CW), .HOST_WIDTH(HW), .CMD_ADDR_WIDTH(AW),
    .READ_LATENCY(RL), .CORE_SEL_WIDTH(CSW)
  ) dut (
    .clk(clk), .reset(rst_n),
    .host_wvalid(host_wvalid), .host_wready(host_wready),
    .host_waddr(host_waddr), .host_wdata(host_wdata),
    .commit_pulse(commit_pulse), .err_seq(err_seq), .err_addr(err_addr),
    .commit_count(commit_count),
`ifdef CMD_MEM_READBACK_EN
    .host_raddr(host_raddr), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_rdvalid(host_rdvalid),
`endif
    .instr_ptr(instr_ptr), .cmd_out(cmd_out)
  );

  int n_pass = 0, n_tot = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // The model keeps the memory contents, the command being assembled and a pending commit.
  // It also keeps a history of values sampled by the read ports.
  typedef struct packed { logic [1:0] kn; logic [NC*CW-1:0] d; } rd_t;
  logic [CW-1:0] mm [NC][8];
  bit            mk [NC][8];
  bit            f_act = 0, c_pend = 0;
  int            f_core, f_addr, f_next, c_core, c_addr;
  logic [CW-1:0] f_data, c_data;
  int            e_count = 0;
  bit            e_commit = 0, e_seq = 0, e_addr = 0;
  rd_t           rq[$];

  initial begin
    rd_t r;
    logic [AW-1:0] p;
    bit acc;
    int wc, wa, wch;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        f_act = 0; c_pend = 0; e_count = 0;
        e_commit = 0; e_seq = 0; e_addr = 0;
        rq.delete();
      end else begin
        for (int c = 0; c < NC; c++) begin
          p = instr_ptr[c*AW +: AW];
          r.d[c*CW +: CW] = mm[c][p[2:0]];
          r.kn[c] = mk[c][p[2:0]];
        end
        rq.push_front(r);
        if (rq.size() > RL) void'(rq.pop_back());
        acc = host_wvalid && !c_pend;
        e_commit = 0; e_seq = 0; e_addr = 0;
        if (c_pend) begin
          mm[c_core][c_addr] = c_data;
          mk[c_core][c_addr] = 1;
          e_count++;
          e_commit = 1;
          c_pend = 0;
        end
        if (acc) begin
          wc  = int'(host_waddr[HAW-1 -: CSW]);
          wa  = int'(host_waddr[AW+1:2]);
          wch = int'(host_waddr[1:0]);
          if (wc >= NC) begin
            e_addr = 1;
            f_act = 0;
          end else if (f_act && wc == f_core && wa == f_addr && wch == f_next) begin
            f_data[wch*HW +: HW] = host_wdata;
            f_next++;
            if (f_next == CW / HW) begin
              c_pend = 1; c_core = f_core; c_addr = f_addr; c_data = f_data;
              f_act = 0;
            end
          end else begin
            if (f_act || wch != 0) e_seq = 1;
            f_act = 0;
            if (wch == 0) begin
              f_act = 1; f_core = wc; f_addr = wa; f_next = 1;
              f_data = '0;
              f_data[HW-1:0] = host_wdata;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    rd_t r;
    forever begin
      @(negedge clk);
      check("wready", host_wready, !c_pend);
      check("commit_pulse", commit_pulse, e_commit);
      check("err_seq", err_seq, e_seq);
      check("err_addr", err_addr, e_addr);
      check("commit_count", commit_count, 32'(e_count));
      if (rq.size() >= RL) r = rq[RL-1];
      else begin r.kn = 2'b11; r.d = '0; end
      for (int c = 0; c < NC; c++)
        if (r.kn[c]) check($sformatf("cmd_out%0d", c), cmd_out[c*CW +: CW], r.d[c*CW +: CW]);
    end
  end

  // ---------------- stimulus ----------------
  bit rand_ptr0 = 1, rand_ptr1 = 1;
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rand_ptr0) ptr0 = AW'($urandom % 8);
      if (rand_ptr1) ptr1 = AW'($urandom % 8);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic put(input int core, input int addr, input int ch, input logic [31:0] d);
    host_wvalid = 1'b1;
    host_waddr  = {CSW'(core), AW'(addr), 2'(ch)};
    host_wdata  = d;
    @(posedge clk); #2;
    host_wvalid = 1'b0;
  endtask

  // Sends all four chunks, then waits through the commit edge.
  task automatic write_cmd(input int core, input int addr, input logic [127:0] d);
    for (int i = 0; i < 4; i++) put(core, addr, i, d[i*32 +: 32]);
    @(posedge clk); #2;
  endtask

  localparam logic [127:0] T1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] T4 = 128'hAAAA0004_BBBB0003_CCCC0002_DDDD0001;
  localparam logic [127:0] T5 = 128'h0BADF00D_12345678_9ABCDEF0_55AA55AA;

  initial begin
    int r, s_ch, s_core, s_addr;
    s_ch = 0; s_core = 0; s_addr = 0;
    #1 rst_n = 1'b0;
    idle(2);
    check("rst_wready", host_wready, 1'b1);
    check("rst_count", commit_count, 32'd0);
    check("rst_cmd_out", cmd_out, '0);
    rst_n = 1'b1;
    idle(1);

    // Fill every address the bench uses so all reads have known data.
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < 8; a++)
        write_cmd(c, a, {$urandom, $urandom, $urandom, $urandom});
    check("preload_count", commit_count, 32'd16);

    // Single command, then read it back through core 0.
    rand_ptr0 = 0; ptr0 = '0;
    write_cmd(0, 5, T1);
    check("t1_commit_pulse", commit_pulse, 1'b1);
    check("t1_count", commit_count, 32'd17);
    ptr0 = AW'(5);
    idle(3);
    check("t1_pulse_gone", commit_pulse, 1'b0);
    check("t1_cmd_out0", cmd_out[CW-1:0], T1);

`ifdef CMD_MEM_READBACK_EN
    host_raddr = {CSW'(0), AW'(5), 2'(2)};
    host_rvalid = 1'b1;
    @(posedge clk); #2;
    host_rvalid = 1'b0;
    idle(2);
    check("rb_valid", host_rdvalid, 1'b1);
    check("rb_data", host_rdata, 32'h33333333);
`endif

    // Skip from chunk 1 to chunk 3.
    put(1, 2, 0, 32'hDEAD0000);
    put(1, 2, 1, 32'hDEAD0001);
    put(1, 2, 3, 32'hDEAD0003);
    check("t2_err_seq", err_seq, 1'b1);
    rand_ptr1 = 0; ptr1 = AW'(2);
    idle(4);
    check("t2_count", commit_count, 32'd17);
    rand_ptr1 = 1;

    // Core field out of range, then one good command.
    put(2, 0, 0, 32'hBAD0BAD0);
    check("t3_err_addr", err_addr, 1'b1);
    check("t3_no_seq", err_seq, 1'b0);
    write_cmd(0, 1, {$urandom, $urandom, $urandom, $urandom});
    check("t3_count", commit_count, 32'd18);

    // Same-edge read/commit collision on core 0 address 5.
    write_cmd(0, 5, T4);
    idle(2);
    check("t4_old_data", cmd_out[CW-1:0], T1);
    idle(1);
    check("t4_new_data", cmd_out[CW-1:0], T4);
    check("t4_count", commit_count, 32'd19);

    // Random traffic: mostly well-formed sequences, mixed with junk chunks.
    rand_ptr0 = 1;
    for (int k = 0; k < 2000; k++) begin
      r = $urandom % 100;
      if (c_pend || r < 15) begin
        host_wvalid = 1'b0;
      end else if (r < 22) begin
        host_wvalid = 1'b1;
        host_waddr  = {CSW'($urandom % 4), AW'($urandom % 8), 2'($urandom % 4)};
        host_wdata  = $urandom;
      end else begin
        if (s_ch == 0) begin s_core = $urandom % 2; s_addr = $urandom % 8; end
        host_wvalid = 1'b1;
        host_waddr  = {CSW'(s_core), AW'(s_addr), 2'(s_ch)};
        host_wdata  = $urandom;
        s_ch = (s_ch + 1) % 4;
      end
      @(posedge clk); #2;
    end
    host_wvalid = 1'b0;
    idle(4);

    // Assert reset in the middle of a fill.
    put(0, 3, 0, 32'h01010101);
    put(0, 3, 1, 32'h02020202);
    #1 rst_n = 1'b0;
    #1;
    check("t5_wready", host_wready, 1'b1);
    check("t5_pulse", commit_pulse, 1'b0);
    check("t5_err", {err_seq, err_addr}, 2'b00);
    check("t5_count", commit_count, 32'd0);
    check("t5_cmd_out", cmd_out, '0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    idle(1);
    rand_ptr0 = 0; ptr0 = AW'(3);
    write_cmd(0, 3, T5);
    check("t5_commit", commit_pulse, 1'b1);
    check("t5_count_after", commit_count, 32'd1);
    idle(3);
    check("t5_cmd_out0", cmd_out[CW-1:0], T5);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
